fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl: fetch-stage PC / IF/ID sequencing with I-cache line refill.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   pc,
    input  logic                          icache_hit,
    input  logic                          branch_taken,
    input  logic                          load_use_hazard,
    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    input  logic                          mem_ready,
    input  logic [31:0]                   mem_rdata,
    output logic                          refill_we,
    output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
    output logic [31:0]                   refill_data,
    output logic                          pc_write,
    output logic                          ifid_write,
    output logic                          ifid_flush,
    output logic [CNT_W-1:0]              miss_count
);

    localparam int                IDX_W       = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [31:0]       C_LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [IDX_W-1:0]   r_idx,      w_idx_nxt;
    logic [31:0]        r_base,     w_base_nxt;
    logic [CNT_W-1:0]   r_miss_cnt, w_miss_cnt_nxt;
    logic               w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_idx      <= '0;
            r_base     <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_base     <= w_base_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
        end
    end

    // Branch and load-use inputs never stall the refill sequence itself.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_base_nxt     = r_base;
        w_miss_cnt_nxt = r_miss_cnt;
        case (r_state)
            ST_RUN: begin
                if (!icache_hit && !branch_taken) begin
                    w_state_nxt = ST_REFILL;
                    w_idx_nxt   = '0;
                    w_base_nxt  = pc & C_LINE_MASK;
                    if (r_miss_cnt != {CNT_W{1'b1}}) begin
                        w_miss_cnt_nxt = r_miss_cnt + 1'b1;
                    end
                end
            end
            ST_REFILL: begin
                if (mem_ready) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_state_nxt = ST_RESUME;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            ST_RESUME: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign w_run       = (r_state == ST_RUN);

    assign mem_req     = (r_state == ST_REFILL);
    assign mem_addr    = r_base + (32'(r_idx) << 2);
    assign refill_we   = mem_req & mem_ready;
    assign refill_idx  = r_idx;
    assign refill_data = mem_rdata;
    assign miss_count  = r_miss_cnt;

    assign pc_write    = branch_taken | (w_run & icache_hit & !load_use_hazard);
    assign ifid_write  = branch_taken | !load_use_hazard;
    assign ifid_flush  = ifid_write & (branch_taken | !w_run | !icache_hit);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a cycle model of the fetch/refill rules.
`default_nettype none

module tb_fetch_ctrl;

    localparam int LW    = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        icache_hit, branch_taken, load_use_hazard;
    logic        mem_req, mem_ready;
    logic [31:0] mem_addr, mem_rdata, refill_data;
    logic        refill_we, pc_write, ifid_write, ifid_flush;
    logic [1:0]  refill_idx;
    logic [CNT_W-1:0] miss_count;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.LINE_WORDS(LW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .icache_hit(icache_hit),
        .branch_taken(branch_taken), .load_use_hazard(load_use_hazard),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .refill_we(refill_we), .refill_idx(refill_idx),
        .refill_data(refill_data), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a refill is "busy" while words remain, then one settle cycle.
    logic        m_busy, m_settle;
    int          m_words, m_cnt;
    logic [31:0] m_base;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_settle <= 1'b0; m_words <= 0; m_cnt <= 0; m_base <= '0;
        end else if (m_settle) begin
            m_settle <= 1'b0;
        end else if (m_busy) begin
            if (mem_ready) begin
                if (m_words == LW - 1) begin
                    m_busy <= 1'b0; m_settle <= 1'b1; m_words <= 0;
                end else begin
                    m_words <= m_words + 1;
                end
            end
        end else if (!icache_hit && !branch_taken) begin
            m_busy  <= 1'b1;
            m_words <= 0;
            m_base  <= (pc / (LW * 4)) * (LW * 4);
            m_cnt   <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
    end

    always @(negedge clk) begin
        logic run, e_iw;
        run  = !m_busy && !m_settle;
        e_iw = branch_taken | !load_use_hazard;
        chk("pc_write",   pc_write,   branch_taken | (run & icache_hit & !load_use_hazard));
        chk("ifid_write", ifid_write, e_iw);
        chk("ifid_flush", ifid_flush, e_iw & (branch_taken | !run | !icache_hit));
        chk("mem_req",    mem_req,    m_busy);
        chk("refill_we",  refill_we,  m_busy & mem_ready);
        chk("miss_count", miss_count, m_cnt);
        if (m_busy) begin
            chk("mem_addr",   mem_addr,   m_base + 32'(m_words * 4));
            chk("refill_idx", refill_idx, m_words);
            if (mem_ready) chk("refill_data", refill_data, mem_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        icache_hit = 1'b1; mem_ready = 1'b1; load_use_hazard = 1'b0; branch_taken = 1'b0;
        while (m_busy || m_settle) begin
            tick();
            n++;
            if (n > 30) begin
                errors++;
                $display("FAIL drain_timeout: got %0d cycles expected <= 30", n);
                break;
            end
        end
    endtask

    initial begin
        int stalls, wes, n;
        rst_n = 1'b0; pc = '0; icache_hit = 1'b1; branch_taken = 1'b0;
        load_use_hazard = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_refill_we", refill_we, 0);
        chk("rst_pc_write", pc_write, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Steady hits
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hit_pc_write", pc_write, 1);
            chk("hit_ifid_flush", ifid_flush, 0);
            tick();
        end

        // Zero-wait miss at 0x14
        pc = 32'h14; icache_hit = 1'b0; mem_ready = 1'b1; stalls = 0;
        #1;
        chk("miss_flush", ifid_flush, 1);
        chk("miss_req_T", mem_req, 0);
        stalls += !pc_write;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("zw_addr", mem_addr, 32'h10 + 32'(4 * k));
            chk("zw_idx", refill_idx, k);
            chk("zw_we", refill_we, 1);
            stalls += !pc_write;
            tick();
        end
        icache_hit = 1'b1;
        #1;
        chk("zw_resume_req", mem_req, 0);
        stalls += !pc_write;
        tick();
        #1;
        chk("zw_run_pc_write", pc_write, 1);
        chk("zw_stalls", stalls, 6);
        chk("zw_miss_count", miss_count, 1);
        tick();

        // Slow memory: ready every 3rd cycle
        pc = 32'h100; icache_hit = 1'b0; mem_ready = 1'b0; wes = 0; n = 0;
        tick();
        while (1) begin
            mem_ready = (n % 3 == 2);
            #1;
            if (!mem_req) break;
            chk("slow_addr", mem_addr, 32'h100 + 32'(4 * wes));
            chk("slow_pc_write", pc_write, 0);
            if (refill_we) wes++;
            tick();
            n++;
            if (n > 40) begin
                errors++;
                $display("FAIL slow_timeout: got %0d cycles expected <= 40", n);
                break;
            end
        end
        chk("slow_we_pulses", wes, 4);
        icache_hit = 1'b1;
        tick();
        #1;
        chk("slow_run_pc_write", pc_write, 1);
        chk("slow_miss_count", miss_count, 2);
        tick();

        // Load-use hazard on the miss cycle
        pc = 32'h200; icache_hit = 1'b0; load_use_hazard = 1'b1; mem_ready = 1'b1;
        #1;
        chk("luh_iw", ifid_write, 0);
        chk("luh_flush", ifid_flush, 0);
        tick();
        #1;
        chk("luh_req", mem_req, 1);
        chk("luh_iw2", ifid_write, 0);
        tick();
        load_use_hazard = 1'b0;
        #1;
        chk("luh_bubble_iw", ifid_write, 1);
        chk("luh_bubble_flush", ifid_flush, 1);
        drain();

        // Wrong-path miss
        pc = 32'h500; icache_hit = 1'b0; branch_taken = 1'b1;
        #1;
        chk("wp_pc_write", pc_write, 1);
        chk("wp_flush", ifid_flush, 1);
        tick();
        branch_taken = 1'b0; icache_hit = 1'b1;
        #1;
        chk("wp_no_req", mem_req, 0);
        chk("wp_miss_count", miss_count, 3);
        tick();

        // Branch during refill word 1
        pc = 32'h300; icache_hit = 1'b0; mem_ready = 1'b1;
        tick();
        #1 chk("br_idx0", refill_idx, 0);
        tick();
        branch_taken = 1'b1;
        #1;
        chk("br_pc_write", pc_write, 1);
        chk("br_flush", ifid_flush, 1);
        chk("br_idx1", refill_idx, 1);
        tick();
        branch_taken = 1'b0;
        #1 chk("br_idx2", refill_idx, 2);
        tick();
        #1 chk("br_addr3", mem_addr, 32'h30C);
        tick();
        icache_hit = 1'b1;
        #1 chk("br_resume_req", mem_req, 0);
        tick();
        #1 chk("br_run_pc_write", pc_write, 1);
        chk("br_miss_count", miss_count, 4);
        tick();

        // Reset in the middle of a second refill
        pc = 32'h400; icache_hit = 1'b0; mem_ready = 1'b0;
        tick();
        #1 chk("mr_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_req_drop", mem_req, 0);
        chk("mr_miss_count", miss_count, 0);
        chk("mr_addr", mem_addr, 0);
        icache_hit = 1'b1;
        tick();
        rst_n = 1'b1;
        #1 chk("mr_run_pc_write", pc_write, 1);
        tick();

        // Counter saturation
        for (int i = 0; i < 9; i++) begin
            pc = 32'h1000 + 32'(i * 64); icache_hit = 1'b0; mem_ready = 1'b1;
            tick();
            drain();
        end
        #1 chk("sat_miss_count", miss_count, CMAX);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
